// File: rtl/fse_ffe_slicer.sv
// T/2 fractionally spaced FFE with hard slicer, decimated to symbol rate.
// Coefficients are double-buffered and swap into the datapath only on phase-0 captures.
module fse_ffe_tap #(
    parameter int NBx = 8,
    parameter int NBw = 7
) (
    input  logic                       clkA,
    input  logic                       reset,
    input  logic signed [NBx-1:0]      tap_i,
    input  logic signed [NBw-1:0]      w_i,
    output logic signed [NBx+NBw-1:0]  p_o
);
    logic signed [NBx+NBw-1:0] p_q;

    always_ff @(posedge clkA) begin
        if (!reset) p_q <= '0;
        else        p_q <= tap_i * w_i;
    end

    assign p_o = p_q;
endmodule

module fse_ffe_slicer #(
    parameter int NBx  = 8,
    parameter int NBFx = 5,
    parameter int NBy  = 8,
    parameter int NBFy = 5,
    parameter int Nw   = 9,
    parameter int NBw  = 7,
    parameter int NBFw = 5
) (
    input  logic                   clkA,
    input  logic                   reset,
    input  logic signed [NBx-1:0]  x,
    input  logic [Nw*NBw-1:0]      coeff,
    input  logic                   coeff_load,
    output logic signed [NBy-1:0]  y,
    output logic                   d,
    output logic                   out_valid,
    output logic                   sat
);
    localparam int PW     = NBx + NBw;
    localparam int SW     = NBx + NBw + $clog2(Nw);
    localparam int SH     = NBFx + NBFw - NBFy;
    localparam int CW     = $clog2(Nw + 1);
    localparam int STAGES = 3;
    localparam logic [Nw*NBw-1:0] W_IDENT = (Nw*NBw)'(2**NBFw) << (NBw * (Nw/2));
    localparam logic signed [SW-1:0] YMAX = SW'(2**(NBy-1) - 1);
    localparam logic signed [SW-1:0] YMIN = -(SW'(2**(NBy-1)));

    logic [Nw-1:0][NBx-1:0] tap_q;
    logic [Nw-1:0][NBw-1:0] act_q, act_d, shd_q, shd_d;
    logic                   pend_q, pend_d;
    logic                   phase_q;
    logic [CW-1:0]          fill_q, fill_d;
    logic [STAGES:0]        vld_pipe;
    logic signed [PW-1:0]   prod [Nw];
    logic signed [SW-1:0]   sum_d, sum_q;
    logic signed [SW-1:0]   shr;
    logic signed [NBy-1:0]  y_d, y_q;
    logic                   d_d, d_q, sat_d, sat_q;

    // Delay line, phase, fill counter and valid tagging of each capture.
    always_ff @(posedge clkA) begin
        if (!reset) begin
            tap_q    <= '0;
            phase_q  <= 1'b0;
            fill_q   <= '0;
            vld_pipe <= '0;
        end else begin
            tap_q    <= {tap_q[Nw-2:0], x};
            phase_q  <= ~phase_q;
            fill_q   <= fill_d;
            vld_pipe <= {vld_pipe[STAGES-1:0], phase_q && (fill_q == CW'(Nw))};
        end
    end

    assign fill_d = (fill_q == CW'(Nw)) ? fill_q : fill_q + CW'(1);

    // A phase-0 edge commits whatever was pending before it; a load on that
    // same edge becomes the next pending set.
    always_comb begin
        shd_d  = coeff_load ? coeff : shd_q;
        act_d  = act_q;
        pend_d = pend_q | coeff_load;
        if (!phase_q) begin
            if (pend_q) act_d = shd_q;
            pend_d = coeff_load;
        end
    end

    always_ff @(posedge clkA) begin
        if (!reset) begin
            act_q  <= W_IDENT;
            shd_q  <= W_IDENT;
            pend_q <= 1'b0;
        end else begin
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
        end
    end

    for (genvar j = 0; j < Nw; j++) begin : g_tap
        fse_ffe_tap #(.NBx(NBx), .NBw(NBw)) u_tap (
            .clkA  (clkA),
            .reset (reset),
            .tap_i (tap_q[j]),
            .w_i   (act_q[j]),
            .p_o   (prod[j])
        );
    end

    always_comb begin
        sum_d = '0;
        for (int j = 0; j < Nw; j++) sum_d = sum_d + SW'(prod[j]);
    end

    // Floor rescale then clip to the output range.
    always_comb begin
        shr   = sum_q >>> SH;
        sat_d = 1'b0;
        y_d   = shr[NBy-1:0];
        if (shr > YMAX) begin
            y_d   = YMAX[NBy-1:0];
            sat_d = 1'b1;
        end else if (shr < YMIN) begin
            y_d   = YMIN[NBy-1:0];
            sat_d = 1'b1;
        end
        d_d = ~y_d[NBy-1];
    end

    always_ff @(posedge clkA) begin
        if (!reset) begin
            sum_q <= '0;
            y_q   <= '0;
            d_q   <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            y_q   <= y_d;
            d_q   <= d_d;
            sat_q <= sat_d;
        end
    end

    assign y         = y_q;
    assign d         = d_q;
    assign sat       = sat_q;
    assign out_valid = vld_pipe[STAGES];
endmodule
